// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Word-index counter width; a single-word operand still needs a 1-bit index.
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/mw_add_sequencer.sv
// Multi-word add sequencer: time-multiplexes one external nBITS adder over
// NWORDS clocks, least-significant word first, with a registered ripple carry.
module mw_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int nBITS  = 4,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // request side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [nBITS*NWORDS-1:0]  a_in,
  input  logic [nBITS*NWORDS-1:0]  b_in,
  input  logic                     c_in,
  // result side
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [nBITS*NWORDS-1:0]  result,
  output logic                     cout_out,
  output logic                     busy,
  // shared adder interface
  output logic [nBITS-1:0]         ain,
  output logic [nBITS-1:0]         bin,
  output logic                     cin,
  input  logic [nBITS-1:0]         sum,
  input  logic                     cout
);

  localparam int W     = nBITS * NWORDS;
  localparam int IDX_W = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      result_q, result_d;
  logic              cout_q, cout_d;
  logic              accept;

  // Next-state, datapath update and output decode for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    cout_d    = cout_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    ain       = '0;
    bin       = '0;
    cin       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end

      RUN: begin
        busy = 1'b1;
        ain  = a_q[idx_q*nBITS +: nBITS];
        bin  = b_q[idx_q*nBITS +: nBITS];
        cin  = carry_q;
        result_d[idx_q*nBITS +: nBITS] = sum;
        carry_d = cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        res_valid = 1'b1;
        req_ready = res_ready;
        if (res_ready) begin
          if (req_valid) accept  = 1'b1;
          else           state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Capture a new operation; the request inputs are not looked at again until the next accept.
    if (accept) begin
      a_d     = a_in;
      b_d     = b_in;
      carry_d = c_in;
      idx_d   = '0;
      state_d = RUN;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign result   = result_q;
  assign cout_out = cout_q;

endmodule
